// File: rtl/timer_display_driver_pkg.sv
// Shared definitions for the timer display driver: time-bus field layout,
// legal field limits, seven-segment codes (gfedcba, active-low), buffer
// nibble codes and the conversion FSM state type.
package timer_disp_pkg;

  localparam int DIGIT_W = 27;
  localparam int HR_LSB  = 22, HR_W  = 5;
  localparam int MIN_LSB = 16, MIN_W = 6;
  localparam int SEC_LSB = 10, SEC_W = 6;
  localparam int MS_LSB  = 0,  MS_W  = 10;

  localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] NIB_DASH  = 4'hA;
  localparam logic [3:0] NIB_BLANK = 4'hF;

  // Field order matches the bus: {hr, min, sec, ms}.
  typedef struct packed {
    logic [HR_W-1:0]  hr;
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
    logic [MS_W-1:0]  ms;
  } time_word_t;

  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_COMMIT} conv_state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    case (nib)
      4'd0:     seg_encode = SEG_0;
      4'd1:     seg_encode = SEG_1;
      4'd2:     seg_encode = SEG_2;
      4'd3:     seg_encode = SEG_3;
      4'd4:     seg_encode = SEG_4;
      4'd5:     seg_encode = SEG_5;
      4'd6:     seg_encode = SEG_6;
      4'd7:     seg_encode = SEG_7;
      4'd8:     seg_encode = SEG_8;
      4'd9:     seg_encode = SEG_9;
      NIB_DASH: seg_encode = SEG_DASH;
      default:  seg_encode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/timer_display_driver_bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble, 10-bit binary to 4-digit BCD.
// Ports: clk_1khz, reset_in (sync, active-high), start (loads bin and does
// the first shift), bin[9:0], busy, done, bcd[15:0].
// Ten shifts total: one on the start edge and nine while busy. done and bcd
// are combinational and valid only in the cycle of the tenth shift, so the
// caller captures the result on the same edge the converter finishes.
module bin2bcd_seq (
  input  logic        clk_1khz,
  input  logic        reset_in,
  input  logic        start,
  input  logic [9:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  // {bcd[15:0], bin[9:0]} shift register
  logic [25:0] sh, sh_step;
  logic [3:0]  cnt;

  function automatic logic [25:0] dd_step(input logic [25:0] s);
    logic [25:0] t;
    t = s;
    for (int i = 0; i < 4; i++)
      if (t[10+4*i +: 4] >= 4'd5) t[10+4*i +: 4] = t[10+4*i +: 4] + 4'd3;
    return {t[24:0], 1'b0};
  endfunction

  always_comb sh_step = dd_step(sh);

  always_ff @(posedge clk_1khz) begin
    if (reset_in) begin
      sh   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      sh   <= dd_step({16'h0, bin});
      cnt  <= 4'd1;
      busy <= 1'b1;
    end else if (busy) begin
      sh  <= sh_step;
      cnt <= cnt + 4'd1;
      if (cnt == 4'd9) busy <= 1'b0;
    end
  end

  assign done = busy && (cnt == 4'd9);
  assign bcd  = sh_step[25:10];

endmodule

// File: rtl/timer_display_driver.sv
// timer_display_driver: samples the packed {hr,min,sec,ms} time word every
// 42 cycles, converts each field through one shared sequential BCD
// converter and drives an 8-digit multiplexed active-low display as
// HH.MM.SS.cc (cc = ms hundreds/tens). Blinks while done is high.
// Ports: clk_1khz, reset_in (sync, active-high), digit[26:0], done,
// seg[6:0] (gfedcba), dp, an[7:0] (an[7]=H tens .. an[0]=ms tens),
// update_pulse (buffer refreshed), range_err (last snapshot out of range).
module timer_display_driver
  import timer_disp_pkg::*;
#(
  parameter int SCAN_DIV   = 1,
  parameter int BLINK_HALF = 250
) (
  input  logic                clk_1khz,
  input  logic                reset_in,
  input  logic [DIGIT_W-1:0]  digit,
  input  logic                done,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [7:0]          an,
  output logic                update_pulse,
  output logic                range_err
);

  localparam int SDW = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int BDW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  conv_state_t      state, state_nxt;
  time_word_t       snap;
  logic [1:0]       field_idx;
  logic [3:0]       cyc;
  logic [7:0][3:0]  staging, disp_buf;
  logic             snap_err;

  logic             conv_start, conv_busy, conv_done;
  logic [9:0]       conv_bin;
  logic [15:0]      conv_bcd;

  bin2bcd_seq u_bcd (
    .clk_1khz (clk_1khz),
    .reset_in (reset_in),
    .start    (conv_start),
    .bin      (conv_bin),
    .busy     (conv_busy),
    .done     (conv_done),
    .bcd      (conv_bcd)
  );

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clk_1khz) begin
    if (reset_in) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = ST_CONV;
      ST_CONV:   if (cyc == 4'd9 && field_idx == 2'd3) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    update_pulse = (state == ST_COMMIT);
    conv_start   = (state == ST_CONV) && (cyc == 4'd0) && !conv_busy;
  end

  always_comb begin
    case (field_idx)
      2'd0:    conv_bin = {5'd0, snap.hr};
      2'd1:    conv_bin = {4'd0, snap.min};
      2'd2:    conv_bin = {4'd0, snap.sec};
      default: conv_bin = snap.ms;
    endcase
  end

  assign snap_err = (snap.hr > HR_MAX) || (snap.min > MIN_MAX) || (snap.sec > SEC_MAX);

  // Staging is laid out in display order (index 7 = H tens) so COMMIT is a
  // straight copy; ms >= 1000 saturates cc to "99".
  always_ff @(posedge clk_1khz) begin
    if (reset_in) begin
      snap      <= '0;
      field_idx <= '0;
      cyc       <= '0;
      staging   <= '0;
      disp_buf  <= '0;
      range_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          snap      <= time_word_t'(digit);
          field_idx <= '0;
          cyc       <= '0;
        end
        ST_CONV: begin
          if (conv_done) begin
            case (field_idx)
              2'd0:    staging[7:6] <= conv_bcd[7:0];
              2'd1:    staging[5:4] <= conv_bcd[7:0];
              2'd2:    staging[3:2] <= conv_bcd[7:0];
              default: staging[1:0] <= (conv_bcd[15:12] != 4'h0) ? 8'h99 : conv_bcd[11:4];
            endcase
          end
          if (cyc == 4'd9) begin
            cyc       <= '0;
            field_idx <= field_idx + 2'd1;
          end else begin
            cyc <= cyc + 4'd1;
          end
        end
        ST_COMMIT: begin
          disp_buf  <= snap_err ? {8{NIB_DASH}} : staging;
          range_err <= snap_err;
        end
        default: ;
      endcase
    end
  end

  // ---------------- scan and blink ----------------
  logic [SDW-1:0] scan_cnt;
  logic [2:0]     scan_idx;
  logic [BDW-1:0] blink_cnt;
  logic           blink_on, blink_wrap, blink_on_nxt;

  always_ff @(posedge clk_1khz) begin
    if (reset_in) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SDW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign blink_wrap = (blink_cnt == BDW'(BLINK_HALF - 1));
  // Output register uses the next phase so a falling done shows on the very
  // next cycle and phase edges line up with the blink counter.
  assign blink_on_nxt = !done ? 1'b1 : (blink_wrap ? !blink_on : blink_on);

  always_ff @(posedge clk_1khz) begin
    if (reset_in || !done) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_wrap) begin
      blink_cnt <= '0;
      blink_on  <= !blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_1khz) begin
    if (reset_in || !blink_on_nxt) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= 8'hFF;
    end else begin
      seg <= seg_encode(disp_buf[scan_idx]);
      dp  <= !(scan_idx == 3'd6 || scan_idx == 3'd4 || scan_idx == 3'd2);
      an  <= ~(8'b1 << scan_idx);
    end
  end

endmodule

// File: tb/tb_timer_display_driver.sv
module tb_timer_display_driver;

  logic        clk_1khz = 1'b0;
  logic        reset_in = 1'b1;
  logic [26:0] digit    = '0;
  logic        done     = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        update_pulse;
  logic        range_err;

  timer_display_driver #(.SCAN_DIV(1), .BLINK_HALF(4)) dut (
    .clk_1khz     (clk_1khz),
    .reset_in     (reset_in),
    .digit        (digit),
    .done         (done),
    .seg          (seg),
    .dp           (dp),
    .an           (an),
    .update_pulse (update_pulse),
    .range_err    (range_err)
  );

  always #5 clk_1khz = ~clk_1khz;

  typedef struct {
    logic [26:0] d;
    logic [31:0] nib;   // expected nibble per display index, idx0 in [3:0]
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] nib;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [26:0] pack(input int h, input int m, input int s, input int ms);
    return {h[4:0], m[5:0], s[5:0], ms[9:0]};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  4'hA: return 7'h3F;  default: return 7'h7F;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout/none, expected event", name);
  endtask

  // Returns at the negedge inside the COMMIT cycle.
  task automatic wait_upd();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_1khz);
      if (update_pulse === 1'b1) begin ok = 1; break; end
    end
    if (!ok) fail_now("upd_timeout");
  endtask

  // Called at the COMMIT negedge: pop the scoreboard and check one full scan.
  task automatic check_update();
    exp_t       e;
    logic [7:0] seen = '0;
    int         idx;
    if (sb.size() == 0) begin fail_now("sb_empty"); return; end
    e = sb.pop_front();
    @(negedge clk_1khz);
    check("range_err", 32'(range_err), 32'(e.err));
    @(negedge clk_1khz);   // outputs registered from the new buffer from here on
    for (int s = 0; s < 8; s++) begin
      idx = -1;
      for (int k = 0; k < 8; k++) if (an === ~(8'b1 << k)) idx = k;
      if (idx < 0) fail_now("an_onehot");
      else begin
        seen[idx] = 1'b1;
        check($sformatf("seg[%0d]", idx), 32'(seg), 32'(seg_of(e.nib[idx*4 +: 4])));
        check($sformatf("dp[%0d]", idx), 32'(dp), 32'(!(idx == 6 || idx == 4 || idx == 2)));
      end
      if (s < 7) @(negedge clk_1khz);
    end
    check("scan_cover", 32'(seen), 32'hFF);
  endtask

  // Release reset at a negedge; expect index 0 first, zero buffer and the
  // first update_pulse 41 edges later. Returns at that COMMIT negedge.
  task automatic release_check(input string tag);
    bit got = 0;
    reset_in = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk_1khz);
      if (n == 1) check({tag, "_an_first"}, 32'(an), 32'hFE);
      if (n <= 8) check({tag, "_zero_buf"}, 32'(seg), 32'h40);
      if (update_pulse === 1'b1) begin
        check({tag, "_upd_latency"}, n, 41);
        got = 1;
        break;
      end
    end
    if (!got) fail_now({tag, "_upd_timeout"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    bit   found;
    vecs[0] = '{pack(12, 34, 56, 789),  32'h12345678, 1'b0};
    vecs[1] = '{pack(0, 0, 0, 1005),    32'h00000099, 1'b0};
    vecs[2] = '{pack(0, 60, 0, 0),      32'hAAAAAAAA, 1'b1};
    vecs[3] = '{pack(23, 59, 59, 999),  32'h23595999, 1'b0};
    vecs[4] = '{pack(24, 0, 0, 0),      32'hAAAAAAAA, 1'b1};
    vecs[5] = '{pack(0, 0, 60, 0),      32'hAAAAAAAA, 1'b1};
    vecs[6] = '{pack(9, 5, 7, 50),      32'h09050705, 1'b0};
    vecs[7] = '{pack(31, 63, 63, 1023), 32'hAAAAAAAA, 1'b1};

    // reset state
    repeat (3) @(negedge clk_1khz);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_an", 32'(an), 32'hFF);
    check("rst_upd", 32'(update_pulse), 32'h0);
    check("rst_rerr", 32'(range_err), 32'h0);

    sb.push_back('{32'h0, 1'b0});
    release_check("por");
    check_update();

    // table
    for (int v = 0; v < 8; v++) begin
      wait_upd();
      digit = vecs[v].d;
      sb.push_back('{vecs[v].nib, vecs[v].err});
      wait_upd();
      check_update();
    end

    // digit change mid-conversion: old snapshot first, new one next update
    wait_upd();
    digit = pack(1, 2, 3, 400);
    sb.push_back('{32'h01020340, 1'b0});
    repeat (20) @(negedge clk_1khz);
    digit = pack(22, 11, 45, 670);
    sb.push_back('{32'h22114567, 1'b0});
    wait_upd();
    check_update();
    wait_upd();
    check_update();

    // reset in the middle of a conversion
    wait_upd();
    digit = pack(12, 34, 56, 789);
    repeat (20) @(negedge clk_1khz);
    reset_in = 1'b1;
    @(negedge clk_1khz);
    check("mid_rst_an", 32'(an), 32'hFF);
    check("mid_rst_seg", 32'(seg), 32'h7F);
    check("mid_rst_dp", 32'(dp), 32'h1);
    check("mid_rst_upd", 32'(update_pulse), 32'h0);
    sb.push_back('{32'h12345678, 1'b0});
    release_check("mid");
    check_update();

    // blink: runs of 4 off / 4 on, immediate resume when done drops
    done  = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_1khz);
      if (an === 8'hFF) begin found = 1; break; end
    end
    if (!found) fail_now("blink_start");
    else begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk_1khz);
        check("blink_off1", 32'(an), 32'hFF);
      end
      for (int k = 0; k < 4; k++) begin
        @(negedge clk_1khz);
        check("blink_on", 32'(an != 8'hFF), 32'h1);
      end
      for (int k = 0; k < 3; k++) begin
        @(negedge clk_1khz);
        check("blink_off2", 32'(an), 32'hFF);
        if (k == 0) check("blink_seg", 32'(seg), 32'h7F);
      end
      done = 1'b0;
      @(negedge clk_1khz);
      check("blink_resume", 32'(an != 8'hFF), 32'h1);
    end

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
